// File: rtl/div_unit_if.sv
// Handshake and result bundle between the EX-stage issue logic and the divider.
// The master side launches or flushes a division; the slave side returns the results.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             cancel;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output start, cancel, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, cancel, is_signed, dividend, divisor,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: LO receives the quotient, HI the remainder.
// The division runs on operand magnitudes, and the signs are applied in the FINISH cycle.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic      clk,
   input logic      rst,
   div_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state;
   state_t           state_next;
   logic             busy;
   logic             launch;
   logic             last_iter;

   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] quo_acc;
   logic [WIDTH-1:0] dvsr;
   logic [CNT_W-1:0] count;
   logic             sign_q;
   logic             sign_r;
   logic             div_zero;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   assign launch    = (state == IDLE) && bus.start && !bus.cancel;
   assign last_iter = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.cancel) begin
               state_next = IDLE;
            end else if (last_iter) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = 1'b0;
      if (state == RUN || state == FINISH) begin
         busy = 1'b1;
      end
   end

   always_comb begin
      dividend_neg = bus.is_signed && bus.dividend[WIDTH-1];
      divisor_neg  = bus.is_signed && bus.divisor[WIDTH-1];
      dividend_abs = dividend_neg ? -bus.dividend : bus.dividend;
      divisor_abs  = divisor_neg  ? -bus.divisor  : bus.divisor;
   end

   // The trial difference carries one extra bit, and its MSB is the borrow that selects restore vs keep.
   always_comb begin
      shifted  = {rem_acc, quo_acc[WIDTH-1]};
      trial    = shifted - {1'b0, dvsr};
      q_bit    = ~trial[WIDTH];
      rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_next = {quo_acc[WIDTH-2:0], q_bit};
   end

   // A zero divisor never borrows, so the quotient fills with ones and the remainder collects |dividend|.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_acc   <= '0;
         quo_acc   <= '0;
         dvsr      <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         div_zero  <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         done <= 1'b0;
         if (launch) begin
            rem_acc  <= '0;
            quo_acc  <= dividend_abs;
            dvsr     <= divisor_abs;
            count    <= '0;
            sign_q   <= dividend_neg ^ divisor_neg;
            sign_r   <= dividend_neg;
            div_zero <= (bus.divisor == '0);
         end else if (state == RUN && !bus.cancel) begin
            rem_acc <= rem_next;
            quo_acc <= quo_next;
            count   <= count + CNT_W'(1);
         end else if (state == FINISH && !bus.cancel) begin
            quotient  <= (sign_q && !div_zero) ? -quo_acc : quo_acc;
            remainder <= sign_r ? -rem_acc : rem_acc;
            done      <= 1'b1;
         end
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.quotient  = quotient;
   assign bus.remainder = remainder;

endmodule
